// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: round-robin sharing of one single-ported RAM between the
// instruction-fetch port (read-only) and the load/store port. Each transaction
// issues exactly one RAM command cycle, captures the registered RAM result and
// returns it with an error flag on the owning port's response channel.
//
// state   | meaning
// IDLE    | winning port sees req_ready; accept latches the request
// ISSUE   | RAM command driven for one cycle; error flag resolved
// CAPTURE | RAM registered output taken into the response register
// RESP    | owner's resp_valid held with stable data until resp_ready
module ram_port_arbiter #(
  parameter int DATA_WIDTH = 64,
  parameter int RAM_SIZE   = 12
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  if_req_valid_i,
  output logic                  if_req_ready_o,
  input  logic [RAM_SIZE-1:0]   if_addr_i,
  output logic                  if_resp_valid_o,
  input  logic                  if_resp_ready_i,
  output logic [DATA_WIDTH-1:0] if_resp_data_o,
  input  logic                  lsu_req_valid_i,
  output logic                  lsu_req_ready_o,
  input  logic [RAM_SIZE-1:0]   lsu_addr_i,
  input  logic                  lsu_we_i,
  input  logic [2:0]            lsu_memwid_i,
  input  logic [DATA_WIDTH-1:0] lsu_wdata_i,
  output logic                  lsu_resp_valid_o,
  input  logic                  lsu_resp_ready_i,
  output logic [DATA_WIDTH-1:0] lsu_resp_data_o,
  output logic                  lsu_resp_err_o,
  output logic [RAM_SIZE-1:0]   ram_addr_o,
  output logic [1:0]            ram_access_mode_o,
  output logic [2:0]            ram_memwid_o,
  output logic [DATA_WIDTH-1:0] ram_wdata_o,
  input  logic [DATA_WIDTH-1:0] ram_rdata_i,
  input  logic                  ram_illegal_i
);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_t;

  localparam logic       OWN_IF     = 1'b0;
  localparam logic       OWN_LSU    = 1'b1;
  localparam logic [1:0] MODE_NONE  = 2'd0;
  localparam logic [1:0] MODE_READ  = 2'd1;
  localparam logic [1:0] MODE_WRITE = 2'd2;
  localparam logic [2:0] MW_WU      = 3'b110;

  state_t                state;
  logic                  owner;
  logic                  last_grant;
  logic                  err_pending;
  logic                  err_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  if_resp_valid_q;
  logic                  lsu_resp_valid_q;
  logic                  lsu_err_q;
  logic [RAM_SIZE-1:0]   addr_q;
  logic [2:0]            memwid_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [1:0]            mode_q;

  logic if_win;
  logic lsu_win;
  logic lsu_bad;
  logic resp_hs;

  // Grant: a lone requester wins; on a tie the port not granted last wins.
  // Ready is masked while reset is asserted so it reads 0 during reset.
  always_comb begin
    if_win          = if_req_valid_i & (~lsu_req_valid_i | (last_grant == OWN_LSU));
    lsu_win         = lsu_req_valid_i & ~if_win;
    if_req_ready_o  = rst_n & (state == IDLE) & if_win;
    lsu_req_ready_o = rst_n & (state == IDLE) & lsu_win;
    // Stores cannot use the unsigned widths; 111 is undefined for any access.
    lsu_bad         = (lsu_we_i & lsu_memwid_i[2]) | (lsu_memwid_i == 3'b111);
    resp_hs         = (if_resp_valid_q & if_resp_ready_i) |
                      (lsu_resp_valid_q & lsu_resp_ready_i);
  end

  assign if_resp_valid_o   = if_resp_valid_q;
  assign lsu_resp_valid_o  = lsu_resp_valid_q;
  assign if_resp_data_o    = rdata_q;
  assign lsu_resp_data_o   = rdata_q;
  assign lsu_resp_err_o    = lsu_err_q;
  assign ram_addr_o        = addr_q;
  assign ram_memwid_o      = memwid_q;
  assign ram_wdata_o       = wdata_q;
  assign ram_access_mode_o = mode_q;

  // Transaction sequencer: accept, one command cycle, capture, respond.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      owner            <= OWN_IF;
      last_grant       <= OWN_LSU;
      err_pending      <= 1'b0;
      err_q            <= 1'b0;
      rdata_q          <= '0;
      if_resp_valid_q  <= 1'b0;
      lsu_resp_valid_q <= 1'b0;
      lsu_err_q        <= 1'b0;
      addr_q           <= '0;
      memwid_q         <= '0;
      wdata_q          <= '0;
      mode_q           <= MODE_NONE;
    end else begin
      case (state)
        IDLE: begin
          if (if_win | lsu_win) begin
            owner       <= lsu_win;
            last_grant  <= lsu_win;
            addr_q      <= lsu_win ? lsu_addr_i : if_addr_i;
            memwid_q    <= lsu_win ? lsu_memwid_i : MW_WU;
            wdata_q     <= lsu_win ? lsu_wdata_i : '0;
            err_pending <= lsu_win & lsu_bad;
            // The command is armed here so it is live for exactly the ISSUE cycle.
            if (lsu_win & lsu_bad)       mode_q <= MODE_NONE;
            else if (lsu_win & lsu_we_i) mode_q <= MODE_WRITE;
            else                         mode_q <= MODE_READ;
            state       <= ISSUE;
          end
        end
        ISSUE: begin
          mode_q <= MODE_NONE;
          err_q  <= err_pending | ram_illegal_i;
          state  <= CAPTURE;
        end
        CAPTURE: begin
          if (err_q)                rdata_q <= '0;
          else if (owner == OWN_IF) rdata_q <= {{(DATA_WIDTH-32){1'b0}}, ram_rdata_i[31:0]};
          else                      rdata_q <= ram_rdata_i;
          if_resp_valid_q  <= (owner == OWN_IF);
          lsu_resp_valid_q <= (owner == OWN_LSU);
          lsu_err_q        <= (owner == OWN_LSU) & err_q;
          state            <= RESP;
        end
        RESP: begin
          if (resp_hs) begin
            if_resp_valid_q  <= 1'b0;
            lsu_resp_valid_q <= 1'b0;
            lsu_err_q        <= 1'b0;
            state            <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Testbench for ram_port_arbiter with a behavioural RAM: 1-cycle registered
// read with width extension, write echo, and an illegal flag for addr[11]=1.
module tb_ram_port_arbiter;

  logic        clk;
  logic        rst_n;
  logic        if_req_valid, if_req_ready, if_resp_valid, if_resp_ready;
  logic [11:0] if_addr;
  logic [63:0] if_resp_data;
  logic        lsu_req_valid, lsu_req_ready, lsu_we, lsu_resp_valid, lsu_resp_ready, lsu_resp_err;
  logic [11:0] lsu_addr;
  logic [2:0]  lsu_memwid;
  logic [63:0] lsu_wdata, lsu_resp_data;
  logic [11:0] ram_addr;
  logic [1:0]  ram_mode;
  logic [2:0]  ram_memwid;
  logic [63:0] ram_wdata, ram_rdata;
  logic        ram_illegal;

  int tests = 0;
  int fails = 0;
  int cmd_cnt = 0;
  logic [1:0] last_mode = 2'd0;

  ram_port_arbiter #(.DATA_WIDTH(64), .RAM_SIZE(12)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req_valid_i(if_req_valid), .if_req_ready_o(if_req_ready), .if_addr_i(if_addr),
    .if_resp_valid_o(if_resp_valid), .if_resp_ready_i(if_resp_ready), .if_resp_data_o(if_resp_data),
    .lsu_req_valid_i(lsu_req_valid), .lsu_req_ready_o(lsu_req_ready), .lsu_addr_i(lsu_addr),
    .lsu_we_i(lsu_we), .lsu_memwid_i(lsu_memwid), .lsu_wdata_i(lsu_wdata),
    .lsu_resp_valid_o(lsu_resp_valid), .lsu_resp_ready_i(lsu_resp_ready),
    .lsu_resp_data_o(lsu_resp_data), .lsu_resp_err_o(lsu_resp_err),
    .ram_addr_o(ram_addr), .ram_access_mode_o(ram_mode), .ram_memwid_o(ram_memwid),
    .ram_wdata_o(ram_wdata), .ram_rdata_i(ram_rdata), .ram_illegal_i(ram_illegal)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // RAM model
  logic [63:0] mem [4096];

  function automatic logic [63:0] ext(input logic [63:0] w, input logic [2:0] mw);
    case (mw)
      3'b000:  return {{56{w[7]}}, w[7:0]};
      3'b001:  return {{48{w[15]}}, w[15:0]};
      3'b010:  return {{32{w[31]}}, w[31:0]};
      3'b100:  return {56'd0, w[7:0]};
      3'b101:  return {48'd0, w[15:0]};
      3'b110:  return {32'd0, w[31:0]};
      default: return w;
    endcase
  endfunction

  assign ram_illegal = (ram_mode != 2'd0) && ram_addr[11];

  always @(posedge clk) begin
    if (ram_mode == 2'd1) ram_rdata <= ext(mem[ram_addr], ram_memwid);
    else if (ram_mode == 2'd2) begin
      ram_rdata <= ram_wdata;
      if (!ram_illegal) begin
        case (ram_memwid)
          3'b000:  mem[ram_addr][7:0]  <= ram_wdata[7:0];
          3'b001:  mem[ram_addr][15:0] <= ram_wdata[15:0];
          3'b010:  mem[ram_addr][31:0] <= ram_wdata[31:0];
          default: mem[ram_addr]       <= ram_wdata;
        endcase
      end
    end
  end

  // Count RAM command cycles, sampled mid-cycle
  always @(negedge clk) begin
    if (ram_mode != 2'd0) begin
      cmd_cnt   = cmd_cnt + 1;
      last_mode = ram_mode;
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    tests++;
    fails++;
    $display("FAIL %s: timed out waiting for DUT", nm);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_ctrl"}, 64'({if_req_ready, lsu_req_ready, if_resp_valid, lsu_resp_valid, lsu_resp_err, ram_mode}), 64'd0);
    chk({tag, "_ifdata"}, if_resp_data, 64'd0);
    chk({tag, "_lsudata"}, lsu_resp_data, 64'd0);
    chk({tag, "_ramaddr"}, 64'({ram_addr, ram_memwid}), 64'd0);
    chk({tag, "_ramwdata"}, ram_wdata, 64'd0);
  endtask

  // One full transaction on one port; reports data, err, latency, RAM command, leak
  task automatic run_txn(input logic use_lsu, input logic [11:0] a, input logic we,
                         input logic [2:0] mw, input logic [63:0] wd,
                         output logic [63:0] d, output logic e, output int lat,
                         output logic [1:0] cmd, output logic leak);
    int c0;
    int n;
    @(negedge clk);
    if (use_lsu) begin
      lsu_req_valid = 1'b1; lsu_addr = a; lsu_we = we; lsu_memwid = mw; lsu_wdata = wd;
    end else begin
      if_req_valid = 1'b1; if_addr = a;
    end
    #1;
    n = 0;
    while (!(use_lsu ? lsu_req_ready : if_req_ready) && n < 20) begin
      @(negedge clk); #1; n++;
    end
    if (n >= 20) timeout("accept");
    c0 = cmd_cnt;
    @(posedge clk);
    lat  = 0;
    leak = 1'b0;
    do begin
      @(negedge clk);
      if (lat == 0) begin if_req_valid = 1'b0; lsu_req_valid = 1'b0; end
      lat++;
      leak |= use_lsu ? if_resp_valid : lsu_resp_valid;
    end while (!(use_lsu ? lsu_resp_valid : if_resp_valid) && lat < 12);
    d = use_lsu ? lsu_resp_data : if_resp_data;
    e = lsu_resp_err;
    if (cmd_cnt - c0 == 0) cmd = 2'd0;
    else if (cmd_cnt - c0 == 1) cmd = last_mode;
    else cmd = 2'd3;
    if (use_lsu) lsu_resp_ready = 1'b1; else if_resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    lsu_resp_ready = 1'b0;
    if_resp_ready  = 1'b0;
  endtask

  typedef struct {
    logic        use_lsu;
    logic [11:0] addr;
    logic        we;
    logic [2:0]  mw;
    logic [63:0] wdata;
    logic [63:0] exp_data;
    logic        exp_err;
    logic [1:0]  exp_mode;
  } vec_t;

  localparam int NV = 18;
  vec_t vecs [NV];

  initial begin
    logic [63:0] d;
    logic        e, leak, bad;
    logic [1:0]  cmd;
    int          lat, n;

    vecs[0]  = '{1'b0, 12'd5,     1'b0, 3'b110, 64'd0,                   64'h0000_0000_8000_0001, 1'b0, 2'd1};
    vecs[1]  = '{1'b1, 12'd9,     1'b1, 3'b011, 64'h1122_3344_5566_77F0, 64'h1122_3344_5566_77F0, 1'b0, 2'd2};
    vecs[2]  = '{1'b1, 12'd9,     1'b0, 3'b000, 64'd0,                   64'hFFFF_FFFF_FFFF_FFF0, 1'b0, 2'd1};
    vecs[3]  = '{1'b1, 12'd9,     1'b0, 3'b100, 64'd0,                   64'h0000_0000_0000_00F0, 1'b0, 2'd1};
    vecs[4]  = '{1'b1, 12'd9,     1'b0, 3'b001, 64'd0,                   64'h0000_0000_0000_77F0, 1'b0, 2'd1};
    vecs[5]  = '{1'b1, 12'd9,     1'b0, 3'b010, 64'd0,                   64'h0000_0000_5566_77F0, 1'b0, 2'd1};
    vecs[6]  = '{1'b1, 12'd9,     1'b0, 3'b011, 64'd0,                   64'h1122_3344_5566_77F0, 1'b0, 2'd1};
    vecs[7]  = '{1'b1, 12'd9,     1'b1, 3'b101, 64'h0000_0000_0000_AAAA, 64'd0,                   1'b1, 2'd0};
    vecs[8]  = '{1'b1, 12'd9,     1'b0, 3'b011, 64'd0,                   64'h1122_3344_5566_77F0, 1'b0, 2'd1};
    vecs[9]  = '{1'b1, 12'd9,     1'b0, 3'b111, 64'd0,                   64'd0,                   1'b1, 2'd0};
    vecs[10] = '{1'b1, 12'd9,     1'b1, 3'b010, 64'h0123_4567_CAFE_BABE, 64'h0123_4567_CAFE_BABE, 1'b0, 2'd2};
    vecs[11] = '{1'b1, 12'd9,     1'b0, 3'b011, 64'd0,                   64'h1122_3344_CAFE_BABE, 1'b0, 2'd1};
    vecs[12] = '{1'b1, 12'd9,     1'b0, 3'b010, 64'd0,                   64'hFFFF_FFFF_CAFE_BABE, 1'b0, 2'd1};
    vecs[13] = '{1'b1, 12'h800,   1'b0, 3'b011, 64'd0,                   64'd0,                   1'b1, 2'd1};
    vecs[14] = '{1'b0, 12'd9,     1'b0, 3'b110, 64'd0,                   64'h0000_0000_CAFE_BABE, 1'b0, 2'd1};
    vecs[15] = '{1'b1, 12'h800,   1'b1, 3'b000, 64'h0000_0000_0000_0055, 64'd0,                   1'b1, 2'd2};
    vecs[16] = '{1'b1, 12'd5,     1'b0, 3'b010, 64'd0,                   64'hFFFF_FFFF_8000_0001, 1'b0, 2'd1};
    vecs[17] = '{1'b1, 12'd9,     1'b1, 3'b100, 64'h0000_0000_0000_0077, 64'd0,                   1'b1, 2'd0};

    for (int i = 0; i < 4096; i++) mem[i] = 64'd0;
    mem[5] = 64'hDEAD_BEEF_8000_0001;
    ram_rdata = 64'd0;

    rst_n = 1'b0;
    if_req_valid = 1'b1; if_addr = 12'd3; if_resp_ready = 1'b0;
    lsu_req_valid = 1'b1; lsu_addr = 12'd3; lsu_we = 1'b1; lsu_memwid = 3'b011;
    lsu_wdata = 64'h1234; lsu_resp_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1 check_reset("reset");
    if_req_valid = 1'b0; lsu_req_valid = 1'b0;
    @(negedge clk) rst_n = 1'b1;

    // Table-driven single transactions
    for (int i = 0; i < NV; i++) begin
      run_txn(vecs[i].use_lsu, vecs[i].addr, vecs[i].we, vecs[i].mw, vecs[i].wdata, d, e, lat, cmd, leak);
      chk($sformatf("vec%0d_data", i), d, vecs[i].exp_data);
      chk($sformatf("vec%0d_err", i), 64'(e), 64'(vecs[i].exp_err));
      chk($sformatf("vec%0d_latency", i), 64'(lat), 64'd3);
      chk($sformatf("vec%0d_ramcmd", i), 64'(cmd), 64'(vecs[i].exp_mode));
      chk($sformatf("vec%0d_other_valid", i), 64'(leak), 64'd0);
    end
    chk("ram_unchanged_after_bad_store", mem[9], 64'h1122_3344_CAFE_BABE);

    // Simultaneous requests: last grant was LSU, so IF, LSU, IF
    @(negedge clk);
    if_req_valid = 1'b1; if_addr = 12'd5;
    lsu_req_valid = 1'b1; lsu_addr = 12'd9; lsu_we = 1'b0; lsu_memwid = 3'b011;
    for (int r = 0; r < 3; r++) begin
      #1;
      n = 0;
      while (!(if_req_ready | lsu_req_ready) && n < 20) begin @(negedge clk); #1; n++; end
      if (n >= 20) timeout("tie_accept");
      chk($sformatf("tie%0d_grant", r), 64'({if_req_ready, lsu_req_ready}), (r == 1) ? 64'd1 : 64'd2);
      @(posedge clk);
      bad = 1'b0; n = 0;
      do begin
        @(negedge clk);
        bad |= if_req_ready | lsu_req_ready;
        n++;
      end while (!(if_resp_valid | lsu_resp_valid) && n < 12);
      chk($sformatf("tie%0d_busy_ready", r), 64'(bad), 64'd0);
      chk($sformatf("tie%0d_owner", r), 64'({if_resp_valid, lsu_resp_valid}), (r == 1) ? 64'd1 : 64'd2);
      chk($sformatf("tie%0d_data", r), (r == 1) ? lsu_resp_data : if_resp_data,
          (r == 1) ? 64'h1122_3344_CAFE_BABE : 64'h0000_0000_8000_0001);
      if_resp_ready = 1'b1; lsu_resp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      if_resp_ready = 1'b0; lsu_resp_ready = 1'b0;
    end
    if_req_valid = 1'b0; lsu_req_valid = 1'b0;

    // Backpressure on the LSU response, then an immediate IF accept
    @(negedge clk);
    lsu_req_valid = 1'b1; lsu_addr = 12'd9; lsu_we = 1'b0; lsu_memwid = 3'b011;
    #1 chk("bp_req_ready", 64'(lsu_req_ready), 64'd1);
    @(posedge clk);
    n = 0;
    do begin
      @(negedge clk);
      lsu_req_valid = 1'b0;
      n++;
    end while (!lsu_resp_valid && n < 12);
    if (n >= 12) timeout("bp_resp");
    chk("bp_data", lsu_resp_data, 64'h1122_3344_CAFE_BABE);
    bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bad |= !lsu_resp_valid || (lsu_resp_data !== 64'h1122_3344_CAFE_BABE) || lsu_resp_err;
    end
    chk("bp_hold", 64'(bad), 64'd0);
    lsu_resp_ready = 1'b1;
    if_req_valid = 1'b1; if_addr = 12'd9;
    #1 chk("bp_no_accept_in_resp", 64'(if_req_ready), 64'd0);
    @(posedge clk);
    @(negedge clk);
    lsu_resp_ready = 1'b0;
    #1 chk("bp_accept_next", 64'({if_req_ready, lsu_resp_valid}), 64'd2);
    @(posedge clk);
    n = 0;
    do begin
      @(negedge clk);
      if_req_valid = 1'b0;
      n++;
    end while (!if_resp_valid && n < 12);
    chk("bp_if_latency", 64'(n), 64'd3);
    chk("bp_if_data", if_resp_data, 64'h0000_0000_CAFE_BABE);
    if_resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if_resp_ready = 1'b0;

    // Reset during CAPTURE, then a fresh tie that IF must win
    @(negedge clk);
    if_req_valid = 1'b1; if_addr = 12'd5;
    #1 chk("rst_pre_accept", 64'(if_req_ready), 64'd1);
    @(posedge clk);
    @(negedge clk);
    if_req_valid = 1'b0;
    @(negedge clk);
    chk("rst_pre_state_capture", 64'({if_resp_valid, ram_mode}), 64'd0);
    if_req_valid = 1'b1;
    lsu_req_valid = 1'b1; lsu_addr = 12'd9; lsu_we = 1'b0; lsu_memwid = 3'b011;
    rst_n = 1'b0;
    #1 check_reset("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("midrst_tie_grant", 64'({if_req_ready, lsu_req_ready}), 64'd2);
    @(posedge clk);
    n = 0;
    bad = 1'b0;
    do begin
      @(negedge clk);
      if_req_valid = 1'b0; lsu_req_valid = 1'b0;
      bad |= lsu_resp_valid;
      n++;
    end while (!if_resp_valid && n < 12);
    chk("midrst_latency", 64'(n), 64'd3);
    chk("midrst_data", if_resp_data, 64'h0000_0000_8000_0001);
    chk("midrst_lsu_valid", 64'(bad), 64'd0);
    if_resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if_resp_ready = 1'b0;
    #1 chk("final_idle", 64'({if_resp_valid, lsu_resp_valid}), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ram_port_arbiter.md
# ram_port_arbiter

Two-port arbiter and access sequencer in front of the single-ported data/instruction RAM (64-bit words, 1-cycle registered read). It shares the RAM between the instruction-fetch port (read-only) and the load/store port using round-robin arbitration and valid/ready handshakes. It drives the RAM command for exactly one cycle per transaction, captures the RAM result into a holding register, and returns it with an error flag.

## Interface
- DATA_WIDTH, 64, RAM word width
- RAM_SIZE, 12, RAM word-address width
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- if_req_valid_i  in  1  fetch request valid
- if_req_ready_o  out  1  fetch request accepted
- if_addr_i  in  RAM_SIZE  fetch word address
- if_resp_valid_o  out  1  fetch response valid
- if_resp_ready_i  in  1  fetch response consumed
- if_resp_data_o  out  DATA_WIDTH  fetch data, zero-extended low 32 bits
- lsu_req_valid_i  in  1  load/store request valid
- lsu_req_ready_o  out  1  load/store request accepted
- lsu_addr_i  in  RAM_SIZE  word address
- lsu_we_i  in  1  1 = store, 0 = load
- lsu_memwid_i  in  3  width code (B=000 H=001 W=010 D=011 BU=100 HU=101 WU=110)
- lsu_wdata_i  in  DATA_WIDTH  store data
- lsu_resp_valid_o  out  1  load/store response valid
- lsu_resp_ready_i  in  1  load/store response consumed
- lsu_resp_data_o  out  DATA_WIDTH  load data / store echo
- lsu_resp_err_o  out  1  illegal access
- ram_addr_o  out  RAM_SIZE  RAM address
- ram_access_mode_o  out  2  0 NONE, 1 READ, 2 WRITE
- ram_memwid_o  out  3  RAM width code
- ram_wdata_o  out  DATA_WIDTH  RAM write data
- ram_rdata_i  in  DATA_WIDTH  RAM registered output
- ram_illegal_i  in  1  RAM combinational illegal flag

## Operation
- FSM states: IDLE, ISSUE, CAPTURE, RESP. Reset → IDLE.
- IDLE: req_ready of the winning port is asserted combinationally; the loser's ready is 0. On handshake, latch owner, addr, we, memwid, wdata. Go to ISSUE. No requests: stay in IDLE.
- Arbitration: a single requester always wins. On a simultaneous request, the port not granted last wins. A last_grant register updates on every accept. Its reset value = LSU, so IF wins the first tie.
- IF requests are loads with memwid fixed at WU (110).
- Pre-check at accept: store with memwid ≥ 100, or memwid = 111 → err_pending = 1.
- ISSUE (one cycle): drive ram_addr/memwid/wdata from the latched values. access_mode = WRITE for a store, READ for a load. If err_pending, access_mode = NONE. Set err = err_pending | (ram_illegal_i & ~err_pending). Go to CAPTURE.
- CAPTURE: register ram_rdata_i into the response data register. If err, register 0. Go to RESP.
- RESP: assert the owner's resp_valid and hold data/err stable until resp_ready. On the handshake cycle, go to IDLE. No new accept happens in RESP.
- Outside ISSUE: ram_access_mode_o = NONE. The other ram_* outputs hold their latched values.
- Store response data = RAM's write echo, passed through unmodified.
- The non-owner port's resp_valid stays 0 throughout.

## Timing
- Reset (async, immediate): state IDLE; all *_ready_o, *_resp_valid_o, lsu_resp_err_o = 0; response data = 0; ram_access_mode_o = NONE; ram_addr/memwid/wdata = 0; last_grant = LSU.
- Latency: accept edge at cycle N → ISSUE in N+1 → CAPTURE in N+2 → resp_valid high in N+3. The earliest next accept is N+4 if resp_ready is high in N+3. Peak throughput is 1 transaction per 4 cycles.
- Exactly one RAM command cycle per transaction. A store writes RAM at the end of ISSUE.
- resp_ready is ignored unless resp_valid is high. Backpressure holds RESP indefinitely with outputs stable.
- req_valid dropped before handshake: no state change. Requests pending during a busy period see ready = 0.
- Reset mid-transaction: the transaction is dropped with no response. A store already past its ISSUE edge remains written.

## Test plan
- Single IF fetch: RAM[5] = 0xDEADBEEF_80000001, if_addr = 5 → if_resp_data = 0x00000000_80000001 at accept+3, one READ cycle seen on RAM.
- LSU store D then load B: store 0x11223344_556677F0 at addr 9, then load B at addr 9 → lsu_resp_data = 0xFFFF_FFFF_FFFF_FFF0, err = 0.
- Simultaneous IF+LSU requests, three rounds → grants IF, LSU, IF. The losing port's ready stays 0 until IDLE.
- Store with memwid = 101 → no WRITE on RAM (mode stays NONE), lsu_resp_err = 1, data = 0, RAM contents unchanged.
- Backpressure: lsu_resp_ready low for 5 cycles → resp_valid/data held constant. Next accept occurs the cycle after the handshake.
- Reset asserted during CAPTURE → all outputs at reset values immediately. After release, a fresh IF request completes normally with IF winning the first tie.
